// File: rtl/lq_mem_issue.sv
// lq_mem_issue: issues the oldest address-ready load-queue entry to memory and returns its data.
// Optional watchdog on the response wait is enabled with LQ_MEM_TIMEOUT_EN.
module lq_mem_issue #(
    parameter int LQ_SIZE        = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_lq_clean,
    input  logic [$clog2(LQ_SIZE)-1:0] i_lq_head_idx,
    input  logic [LQ_SIZE-1:0]         i_lq_entry_pending,
    input  logic [64*LQ_SIZE-1:0]      i_lq_entry_base,
    input  logic [16*LQ_SIZE-1:0]      i_lq_entry_disp,
    output logic                       o_mem_req_valid,
    output logic [63:0]                o_mem_req_addr,
    input  logic                       i_mem_req_ready,
    input  logic                       i_mem_resp_valid,
    input  logic [63:0]                i_mem_resp_data,
    output logic [63:0]                o_lq_mem_data_out,
    output logic [LQ_SIZE-1:0]         o_lq_mem_data_valid,
    output logic                       o_lq_issue_busy,
    output logic                       o_lq_mem_timeout
);
    localparam int IW = $clog2(LQ_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DELIVER, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_sel_idx, w_sel, w_idx;
    logic          w_any, w_tmo;
    logic [63:0]   r_addr, r_data, w_base, w_addr;
    logic [15:0]   w_disp;

    // Descending scan so the entry closest to the head wins.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = LQ_SIZE - 1; k >= 0; k--) begin
            w_idx = i_lq_head_idx + IW'(k);
            if (i_lq_entry_pending[w_idx]) begin
                w_sel = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_base = i_lq_entry_base[{w_sel, 6'd0} +: 64];
    assign w_disp = i_lq_entry_disp[{w_sel, 4'd0} +: 16];
    assign w_addr = w_base + {{48{w_disp[15]}}, w_disp};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (w_any && !i_lq_clean) ? S_REQ : S_IDLE;
            S_REQ:     w_next = i_lq_clean ? S_IDLE : i_mem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:    w_next = i_mem_resp_valid ? (i_lq_clean ? S_IDLE : S_DELIVER) :
                                w_tmo ? S_IDLE : i_lq_clean ? S_DRAIN : S_WAIT;
            S_DELIVER: w_next = S_IDLE;
            S_DRAIN:   w_next = (i_mem_resp_valid || w_tmo) ? S_IDLE : S_DRAIN;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_sel_idx <= '0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_REQ) begin
                r_sel_idx <= w_sel;
                r_addr    <= w_addr;
            end
            if (r_state == S_WAIT && i_mem_resp_valid)
                r_data <= i_mem_resp_data;
        end
    end

    assign o_mem_req_valid     = (r_state == S_REQ);
    assign o_mem_req_addr      = r_addr;
    assign o_lq_mem_data_out   = r_data;
    assign o_lq_issue_busy     = (r_state != S_IDLE);
    assign o_lq_mem_data_valid = (r_state == S_DELIVER && !i_lq_clean) ?
                                 (LQ_SIZE'(1) << r_sel_idx) : '0;

`ifdef LQ_MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // Counter restarts on every state change, so it holds cycles spent in the current state.
    assign w_tmo = (r_state == S_WAIT || r_state == S_DRAIN) && !i_mem_resp_valid &&
                   (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
            r_timeout <= r_timeout | w_tmo;
        end
    end

    assign o_lq_mem_timeout = r_timeout;
`else
    assign w_tmo = 1'b0;
    // No watchdog in this build; the limit only participates to keep the interface uniform.
    assign o_lq_mem_timeout = (TIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_lq_mem_issue.sv
module tb_lq_mem_issue;
`ifdef LQ_MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif
    localparam int N = 8;

    logic          clk = 0, rst = 1, clean = 0, ready = 0, resp = 0;
    logic [2:0]    head = 0;
    logic [N-1:0]  pend = 0;
    logic [64*N-1:0] base_f = 0;
    logic [16*N-1:0] disp_f = 0;
    logic [63:0]   rdata = 0;
    logic          req_valid, busy, tmo;
    logic [63:0]   req_addr, dout;
    logic [N-1:0]  strobe;
    int            errors = 0, checks = 0;

    lq_mem_issue #(.LQ_SIZE(N), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clock(clk), .i_reset(rst), .i_lq_clean(clean), .i_lq_head_idx(head),
        .i_lq_entry_pending(pend), .i_lq_entry_base(base_f), .i_lq_entry_disp(disp_f),
        .o_mem_req_valid(req_valid), .o_mem_req_addr(req_addr), .i_mem_req_ready(ready),
        .i_mem_resp_valid(resp), .i_mem_resp_data(rdata), .o_lq_mem_data_out(dout),
        .o_lq_mem_data_valid(strobe), .o_lq_issue_busy(busy), .o_lq_mem_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   head;
        logic [N-1:0] pend;
        int           idx;
        logic [63:0]  base;
        logic [15:0]  disp;
        logic [63:0]  addr;
        int           rdly;
        int           sdly;
        logic [63:0]  data;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [2:0] h, input logic [N-1:0] p);
        for (int k = 0; k < N; k++)
            if (p[(int'(h) + k) % N]) return (int'(h) + k) % N;
        return -1;
    endfunction

    function automatic logic [63:0] ea(input logic [63:0] b, input logic [15:0] d);
        return b + 64'($signed(d));
    endfunction

    task automatic scramble;
        for (int i = 0; i < N; i++) begin
            base_f[64*i +: 64] = {$urandom, $urandom};
            disp_f[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic run_load(input string nm, input logic [2:0] h, input logic [N-1:0] p,
                            input int idx, input logic [63:0] addr, input int rdly,
                            input int sdly, input logic [63:0] data);
        head = h;
        pend = p;
        tick;
        chk({nm, " req_valid"}, 64'(req_valid), 1);
        chk({nm, " addr"}, req_addr, addr);
        for (int i = 0; i < rdly; i++) begin
            tick;
            chk({nm, " held valid"}, 64'(req_valid), 1);
            chk({nm, " held addr"}, req_addr, addr);
        end
        ready = 1;
        pend = 0;
        tick;
        ready = 0;
        chk({nm, " one accept"}, {62'd0, req_valid, busy}, 64'b01);
        for (int i = 0; i < sdly; i++) begin
            tick;
            chk({nm, " wait strobe"}, 64'(strobe), 0);
        end
        resp = 1;
        rdata = data;
        tick;
        resp = 0;
        chk({nm, " strobe"}, 64'(strobe), 64'(1) << idx);
        chk({nm, " data"}, dout, data);
        tick;
        chk({nm, " end"}, {55'd0, strobe, busy}, 0);
    endtask

    task automatic to_wait(input int idx);
        scramble;
        head = 0;
        pend = N'(1) << idx;
        tick;
        ready = 1;
        pend = 0;
        tick;
        ready = 0;
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{0, 8'b0000_0100, 2, 64'h1000, 16'h0010, 64'h1010, 0, 0, 64'hDEAD_BEEF};
        vt[1] = '{6, 8'b1000_0010, 7, 64'h2000, 16'h0004, 64'h2004, 1, 2, 64'h1111};
        vt[2] = '{6, 8'b0000_0010, 1, 64'h3000, 16'h0000, 64'h3000, 0, 1, 64'h2222};
        vt[3] = '{0, 8'b0000_0001, 0, 64'h8, 16'hFFF8, 64'h0, 5, 0, 64'h3333};
        vt[4] = '{0, 8'b0000_0001, 0, 64'h0, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 3, 64'h4444};
        vt[5] = '{3, 8'b0000_1001, 3, 64'hFFFF_FFFF_FFFF_FFF0, 16'h0020, 64'h10, 0, 0, 64'h5555};
        vt[6] = '{5, 8'b0000_0001, 0, 64'h7FFF, 16'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'h6666};

        tick;
        chk("reset outputs", {dout, req_addr}, 0);
        chk("reset flags", {52'd0, req_valid, busy, tmo, strobe}, 0);
        rst = 0;
        tick;
        chk("idle no pending", {54'd0, req_valid, busy, strobe}, 0);
        ready = 1;
        resp = 1;
        tick;
        chk("stray ready/resp", {54'd0, req_valid, busy, strobe}, 0);
        ready = 0;
        resp = 0;

        foreach (vt[i]) begin
            scramble;
            base_f[64*vt[i].idx +: 64] = vt[i].base;
            disp_f[16*vt[i].idx +: 16] = vt[i].disp;
            run_load($sformatf("vec%0d", i), vt[i].head, vt[i].pend, vt[i].idx, vt[i].addr,
                     vt[i].rdly, vt[i].sdly, vt[i].data);
        end

        for (int n = 0; n < 40; n++) begin
            logic [2:0]   h;
            logic [N-1:0] p;
            int           s;
            scramble;
            h = 3'($urandom);
            p = N'($urandom_range(1, 255));
            s = pick(h, p);
            run_load($sformatf("rand%0d", n), h, p, s,
                     ea(base_f[64*s +: 64], disp_f[16*s +: 16]),
                     $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end

        to_wait(4);
        clean = 1;
        tick;
        clean = 0;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("drain busy", {55'd0, strobe, busy}, 1);
        end
        resp = 1;
        rdata = 64'hBAD;
        tick;
        resp = 0;
        chk("drain done", {55'd0, strobe, busy}, 0);
        tick;
        chk("drain no pulse", {55'd0, strobe, busy}, 0);

        scramble;
        pend = 8'h10;
        tick;
        chk("clean req pre", 64'(req_valid), 1);
        clean = 1;
        pend = 0;
        tick;
        clean = 0;
        chk("clean req", {62'd0, req_valid, busy}, 0);

        to_wait(1);
        clean = 1;
        resp = 1;
        tick;
        clean = 0;
        resp = 0;
        chk("clean+resp", {55'd0, strobe, busy}, 0);

        to_wait(6);
        resp = 1;
        rdata = 64'h77;
        tick;
        resp = 0;
        clean = 1;
        #1;
        chk("clean deliver", 64'(strobe), 0);
        tick;
        clean = 0;
        chk("clean deliver idle", {55'd0, strobe, busy}, 0);

`ifdef LQ_MEM_TIMEOUT_EN
        to_wait(2);
        for (int i = 0; i < TMO - 1; i++) begin
            tick;
            chk("tmo waiting", {62'd0, busy, tmo}, 2'b10);
        end
        tick;
        chk("tmo fired", {62'd0, busy, tmo}, 2'b01);
        resp = 1;
        tick;
        resp = 0;
        chk("tmo stray", {54'd0, strobe, busy, tmo}, 1);
`endif

        to_wait(3);
        chk("mid wait busy", 64'(busy), 1);
        rst = 1;
        #1;
        chk("async reset", {52'd0, req_valid, busy, tmo, strobe}, 0);
        chk("async reset data", {dout, req_addr}, 0);
        tick;
        rst = 0;
        tick;
        chk("post reset", {52'd0, req_valid, busy, tmo, strobe}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
